result_sender: RTL and testbench
================================

RESULT_SENDER -- requirements
Module: result_sender

Interface
REQ-001 Parameter MAX_M, default 4: maximum result rows.
REQ-002 Parameter MAX_P, default 4: maximum result columns.
REQ-003 Parameter CLOCK_FREQ, default 50000000: clk frequency, Hz.
REQ-004 Parameter BAUD_RATE, default 9600: UART bit rate; CLKS_PER_BIT = CLOCK_FREQ/BAUD_RATE, integer division.
REQ-005 Single clock; reset is synchronous and active-high.
REQ-006 clk  input  1  system clock; all logic on its rising edge.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 start  input  1  one-cycle request to transmit the result matrix.
REQ-009 m_dim  input  8  row count M of the matrix to send.
REQ-010 p_dim  input  8  column count P of the matrix to send.
REQ-011 result  input  32 x [MAX_M][MAX_P]  result matrix, row-major.
REQ-012 uart_tx  output  1  UART serial line, 8N1, idle high.
REQ-013 busy  output  1  high from the accepted start until done.
REQ-014 done  output  1  one-cycle pulse after the last stop bit completes.
REQ-015 dim_err  output  1  one-cycle pulse when start is rejected for bad dimensions.

Function
REQ-016 Frame order: header byte 0xA5, m_dim byte, p_dim byte, then M*P words in row-major order (row 0 col 0 first), each word 4 bytes MSB first.
REQ-017 Each byte: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); every bit lasts exactly CLKS_PER_BIT cycles.
REQ-018 Bytes are sent back-to-back: the next start bit begins on the cycle after the previous stop bit ends, with no idle gap.
REQ-019 start is accepted only when busy=0 and 1<=m_dim<=MAX_M and 1<=p_dim<=MAX_P; start while busy=1 is ignored, with no effect.
REQ-020 Start with busy=0 and bad dimensions: dim_err=1 on the next cycle, busy stays 0, uart_tx stays high.
REQ-021 On acceptance, m_dim, p_dim and the whole result array are captured into internal registers; later input changes do not affect the transmission.
REQ-022 busy=1 from the cycle after acceptance; the header start bit drives uart_tx low on that same cycle.
REQ-023 FSM states: IDLE, HDR, DIM_M, DIM_P, DATA, DONE.
REQ-024 Transitions: IDLE->HDR on accepted start; HDR->DIM_M->DIM_P->DATA each on byte-complete; DATA stays for 4*M*P bytes; DATA->DONE after the last byte completes; DONE->IDLE after one cycle.
REQ-025 In DONE: done=1 and busy=0, so the next start is accepted in that cycle.
REQ-026 Counters: byte_idx 0..3, col 0..P-1, row 0..M-1; col wraps to 0 and increments row; row wraps only on the final word.
REQ-027 Total busy duration: exactly (3 + 4*M*P) * 10 * CLKS_PER_BIT cycles.
REQ-028 uart_tx=1 whenever state is IDLE or DONE.

Reset
REQ-029 With rst=1 at a clock edge: state=IDLE, uart_tx=1, busy=0, done=0, dim_err=0, all counters and the baud counter 0.
REQ-030 Reset during a transmission aborts it immediately: uart_tx=1 on the next cycle, any partial byte is discarded, and no done pulse is issued.
REQ-031 start asserted together with rst is ignored.

Structure
REQ-032 Shared package matrix_pkg holds HDR_BYTE=8'hA5, the state enum type, and the frame length constants (bits per frame, header bytes).
REQ-033 One sub-module, uart_tx_core (ports clk, rst, tx_start, tx_data[7:0], tx_busy, tx_done, tx), handles baud timing and serialization; result_sender holds the FSM, capture registers and byte selection.
REQ-034 Capture storage: MAX_M*MAX_P*32 flops; byte selection is a registered mux driven by the counters.

Verification (CLOCK_FREQ=160, BAUD_RATE=10, so CLKS_PER_BIT=16)
REQ-035 M=1, P=1, result[0][0]=32'h12345678, start -> bytes A5,01,01,12,34,56,78; busy lasts 7*160=1120 cycles; done pulses once.
REQ-036 M=2, P=2, words 1,2,3,4 -> bytes A5,02,02, then 00,00,00,01 .. 00,00,00,04 in row-major order; result changed mid-transmission -> sent bytes unchanged.
REQ-037 start with m_dim=0, then with p_dim=5 -> dim_err pulse each time, uart_tx constant 1, busy 0.
REQ-038 Second start while busy -> ignored; start during the DONE cycle -> new frame's header start bit on the next cycle.
REQ-039 rst asserted mid-word (during the 5th byte) -> uart_tx=1 on the next cycle, busy=0, no done; a following start -> complete, correct frame.
REQ-040 Bit-timing check: every uart_tx low/high transition is a multiple of 16 cycles from the first start-bit edge; every stop bit is 1.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared definitions for the result_sender UART framer: header byte, frame
// constants, FSM state type and the word-to-byte selector.
package matrix_pkg;

  localparam logic [7:0] HDR_BYTE       = 8'hA5;
  localparam int         BITS_PER_FRAME = 10;  // start + 8 data + stop
  localparam int         HDR_BYTES      = 3;   // header, m_dim, p_dim

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DIM_M,
    S_DIM_P,
    S_DATA,
    S_DONE
  } state_t;

  // Byte 0 is the most significant byte of the word.
  function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
    case (idx)
      2'd0:    return word[31:24];
      2'd1:    return word[23:16];
      2'd2:    return word[15:8];
      default: return word[7:0];
    endcase
  endfunction

endpackage

// File: rtl/result_sender_if.sv
// Request/result bundle between a matrix producer and result_sender.
interface result_sender_if #(
  parameter int MAX_M = 4,
  parameter int MAX_P = 4
);
  logic                              start;
  logic [7:0]                        m_dim;
  logic [7:0]                        p_dim;
  logic [MAX_M-1:0][MAX_P-1:0][31:0] result;
  logic                              uart_tx;
  logic                              busy;
  logic                              done;
  logic                              dim_err;

  modport master (output start, m_dim, p_dim, result,
                  input  uart_tx, busy, done, dim_err);
  modport slave  (input  start, m_dim, p_dim, result,
                  output uart_tx, busy, done, dim_err);
endinterface

// File: rtl/uart_tx_core.sv
// 8N1 UART serializer. tx_done is high during the last cycle of the stop bit,
// so a tx_start in that cycle chains the next byte with no idle gap.
module uart_tx_core
  import matrix_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx
);

  localparam int                BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]        STOP_IDX  = 4'(BITS_PER_FRAME - 1);

  logic              active;
  logic [BAUD_W-1:0] baud_cnt;
  logic [3:0]        bit_idx;   // 0 start, 1..8 data, 9 stop
  logic [7:0]        shreg;

  assign tx_busy = active;
  assign tx_done = active && (bit_idx == STOP_IDX) && (baud_cnt == BAUD_LAST);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      active   <= 1'b0;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
    end else if (tx_start && (!active || tx_done)) begin
      active   <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= tx_data;
      tx       <= 1'b0;
    end else if (active) begin
      if (baud_cnt == BAUD_LAST) begin
        baud_cnt <= '0;
        if (bit_idx == STOP_IDX) begin
          active  <= 1'b0;
          bit_idx <= '0;
          tx      <= 1'b1;
        end else begin
          bit_idx <= bit_idx + 4'd1;
          tx      <= (bit_idx == 4'd8) ? 1'b1 : shreg[bit_idx[2:0]];
        end
      end else begin
        baud_cnt <= baud_cnt + BAUD_W'(1);
      end
    end
  end

endmodule

// File: rtl/result_sender.sv
// Captures an M x P result matrix on start and streams header, dimensions and
// row-major words (MSB first) over a back-to-back 8N1 UART.
module result_sender
  import matrix_pkg::*;
#(
  parameter int MAX_M      = 4,
  parameter int MAX_P      = 4,
  parameter int CLOCK_FREQ = 50000000,
  parameter int BAUD_RATE  = 9600
) (
  input logic            clk,
  input logic            rst,
  result_sender_if.slave bus
);

  localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int ROW_W        = (MAX_M > 1) ? $clog2(MAX_M) : 1;
  localparam int COL_W        = (MAX_P > 1) ? $clog2(MAX_P) : 1;

  state_t                            state;
  logic [7:0]                        m_cap, p_cap;
  logic [MAX_M-1:0][MAX_P-1:0][31:0] cap;
  logic [1:0]                        byte_idx;
  logic [COL_W-1:0]                  col;
  logic [ROW_W-1:0]                  row;
  logic [7:0]                        byte_reg;   // byte loaded at the next tx_done
  logic                              busy_q, done_q, dim_err_q;

  logic             tx_start, tx_busy, tx_done, tx_line;
  logic [7:0]       tx_data;
  logic             ready, dims_ok, accept;
  logic             word_end, col_end, row_end, last_byte;
  logic [1:0]       nxt_byte_idx;
  logic [COL_W-1:0] nxt_col;
  logic [ROW_W-1:0] nxt_row;

  // NOTE: every signal gets a default before any branch so no latch is inferred.
  always_comb begin
    ready    = ((state == S_IDLE) || (state == S_DONE)) && !tx_busy;
    dims_ok  = (bus.m_dim != 8'd0) && (bus.m_dim <= 8'(MAX_M)) &&
               (bus.p_dim != 8'd0) && (bus.p_dim <= 8'(MAX_P));
    accept   = !rst && bus.start && ready && dims_ok;

    word_end  = (byte_idx == 2'd3);
    col_end   = (8'(col) == p_cap - 8'd1);
    row_end   = (8'(row) == m_cap - 8'd1);
    last_byte = word_end && col_end && row_end;

    nxt_byte_idx = byte_idx + 2'd1;
    nxt_col      = col;
    nxt_row      = row;
    if (word_end) begin
      if (col_end) begin
        nxt_col = '0;
        nxt_row = row_end ? '0 : row + ROW_W'(1);
      end else begin
        nxt_col = col + COL_W'(1);
      end
    end

    tx_start = accept || (tx_done && !((state == S_DATA) && last_byte));
    tx_data  = accept ? HDR_BYTE : byte_reg;
  end

  // NOTE: the capture array is pure datapath and is overwritten on every
  // accepted start, so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept) cap <= bus.result;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      m_cap     <= '0;
      p_cap     <= '0;
      byte_idx  <= '0;
      col       <= '0;
      row       <= '0;
      byte_reg  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dim_err_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      dim_err_q <= bus.start && ready && !dims_ok;
      case (state)
        S_IDLE, S_DONE: begin
          state <= S_IDLE;
          if (accept) begin
            state  <= S_HDR;
            busy_q <= 1'b1;
            m_cap  <= bus.m_dim;
            p_cap  <= bus.p_dim;
          end
        end
        S_HDR: begin
          byte_reg <= m_cap;
          if (tx_done) state <= S_DIM_M;
        end
        S_DIM_M: begin
          byte_reg <= p_cap;
          if (tx_done) state <= S_DIM_P;
        end
        S_DIM_P: begin
          byte_reg <= word_byte(cap[row][col], byte_idx);
          if (tx_done) state <= S_DATA;
        end
        S_DATA: begin
          // Counters name the byte on the wire; byte_reg holds its successor.
          byte_reg <= word_byte(cap[nxt_row][nxt_col], nxt_byte_idx);
          if (tx_done) begin
            byte_idx <= nxt_byte_idx;
            col      <= nxt_col;
            row      <= nxt_row;
            if (last_byte) begin
              state  <= S_DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  uart_tx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clk     (clk),
    .rst     (rst),
    .tx_start(tx_start),
    .tx_data (tx_data),
    .tx_busy (tx_busy),
    .tx_done (tx_done),
    .tx      (tx_line)
  );

  assign bus.uart_tx = tx_line;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.dim_err = dim_err_q;

endmodule

// File: tb/tb_result_sender.sv
// Self-checking bench for result_sender: dimension table, directed frame
// sequences and random frames decoded off uart_tx against a byte-list model.
module tb_result_sender;
  import matrix_pkg::*;

  localparam int CPB = 16;

  logic clk;
  logic rst;

  result_sender_if #(.MAX_M(4), .MAX_P(4)) bus ();

  result_sender #(
    .MAX_M(4), .MAX_P(4), .CLOCK_FREQ(160), .BAUD_RATE(10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [31:0] model_w [4][4];
  logic [7:0]  exp_q[$];
  logic [7:0]  rx_q[$];

  // Line monitor: decodes bytes at mid-bit and checks bit-edge alignment.
  int         mon_phase = -1;
  logic [7:0] mon_byte  = '0;
  logic       prev_tx   = 1'b1;
  logic       prev_busy = 1'b0;
  int         cyc       = 0;
  int         t0        = 0;

  always @(negedge clk) begin
    cyc++;
    if (bus.busy === 1'b1 && prev_busy !== 1'b1) t0 = cyc;
    else if (bus.busy === 1'b1 && bus.uart_tx !== prev_tx)
      check("bit_align", 32'((cyc - t0) % CPB), 32'd0);
    prev_tx   = bus.uart_tx;
    prev_busy = bus.busy;

    if (bus.busy !== 1'b1) mon_phase = -1;
    else if (mon_phase < 0) begin
      if (bus.uart_tx === 1'b0) mon_phase = 0;
    end else begin
      mon_phase++;
      if (mon_phase == CPB / 2)
        check("start_bit", 32'(bus.uart_tx), 32'd0);
      else if (mon_phase >= 24 && mon_phase <= 136 && (mon_phase - 8) % CPB == 0)
        mon_byte[3'((mon_phase - 24) / CPB)] = bus.uart_tx;
      else if (mon_phase == 152) begin
        check("stop_bit", 32'(bus.uart_tx), 32'd1);
        rx_q.push_back(mon_byte);
      end else if (mon_phase == 159) mon_phase = -1;
    end
  end

  task automatic fill_random();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) model_w[r][c] = $urandom;
  endtask

  task automatic drive_inputs(input int m, input int p);
    bus.m_dim = 8'(m);
    bus.p_dim = 8'(p);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) bus.result[r][c] = model_w[r][c];
  endtask

  task automatic expect_frame(input int m, input int p);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'(m));
    exp_q.push_back(8'(p));
    for (int r = 0; r < m; r++)
      for (int c = 0; c < p; c++)
        for (int b = 3; b >= 0; b--) exp_q.push_back(8'(model_w[r][c] >> (8 * b)));
  endtask

  task automatic scramble_inputs();
    bus.m_dim = 8'($urandom_range(1, 4));
    bus.p_dim = 8'($urandom_range(1, 4));
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) bus.result[r][c] = $urandom;
  endtask

  task automatic launch(input string tag);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, "_busy_rise"}, 32'(bus.busy), 32'd1);
    check({tag, "_hdr_start_bit"}, 32'(bus.uart_tx), 32'd0);
  endtask

  // Entered on the first busy negedge; returns on the DONE-cycle negedge
  // (chain=1, with start raised) or one cycle later (chain=0).
  task automatic wait_frame(input string tag, input int m, input int p,
                            input bit mutate, input bit chain);
    int cnt = 1;
    @(negedge clk);
    while (bus.busy === 1'b1 && cnt < 20000) begin
      cnt++;
      bus.start = mutate && (cnt == 300);
      if (mutate && cnt == 300) scramble_inputs();
      @(negedge clk);
    end
    check({tag, "_busy_len"}, 32'(cnt), 32'((HDR_BYTES + 4 * m * p) * BITS_PER_FRAME * CPB));
    check({tag, "_done_pulse"}, 32'(bus.done), 32'd1);
    check({tag, "_idle_line"}, 32'(bus.uart_tx), 32'd1);
    if (chain) bus.start = 1'b1;
    else begin
      @(negedge clk);
      check({tag, "_done_once"}, 32'(bus.done), 32'd0);
    end
  endtask

  task automatic compare_rx(input string tag);
    int n;
    check({tag, "_rx_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_rx_byte%0d", tag, i), 32'(rx_q[i]), 32'(exp_q[i]));
    rx_q.delete();
    exp_q.delete();
  endtask

  typedef struct {
    logic [7:0] m;
    logic [7:0] p;
    logic       exp_err;
    logic       exp_busy;
  } dim_vec_t;

  dim_vec_t vecs [9];

  initial begin
    #(10 * 200000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit saw_done, saw_low;
    int m, p;

    vecs[0] = '{8'd0,   8'd1,   1'b1, 1'b0};
    vecs[1] = '{8'd1,   8'd0,   1'b1, 1'b0};
    vecs[2] = '{8'd5,   8'd1,   1'b1, 1'b0};
    vecs[3] = '{8'd1,   8'd5,   1'b1, 1'b0};
    vecs[4] = '{8'd255, 8'd255, 1'b1, 1'b0};
    vecs[5] = '{8'd1,   8'd1,   1'b0, 1'b1};
    vecs[6] = '{8'd4,   8'd4,   1'b0, 1'b1};
    vecs[7] = '{8'd4,   8'd1,   1'b0, 1'b1};
    vecs[8] = '{8'd0,   8'd5,   1'b1, 1'b0};

    rst = 1'b1;
    bus.start = 1'b0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) model_w[r][c] = '0;
    drive_inputs(1, 1);
    repeat (3) @(negedge clk);
    check("reset_uart_tx", 32'(bus.uart_tx), 32'd1);
    check("reset_busy",    32'(bus.busy),    32'd0);
    check("reset_done",    32'(bus.done),    32'd0);
    check("reset_dim_err", 32'(bus.dim_err), 32'd0);

    // start together with rst is ignored
    bus.start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.start = 1'b0;
    check("rst_start_busy", 32'(bus.busy), 32'd0);
    check("rst_start_tx",   32'(bus.uart_tx), 32'd1);
    @(negedge clk);
    check("rst_start_busy_later", 32'(bus.busy), 32'd0);

    // dimension acceptance table; accepted requests are aborted by reset
    for (int i = 0; i < 9; i++) begin
      bus.m_dim = vecs[i].m;
      bus.p_dim = vecs[i].p;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      check($sformatf("dim%0d_err", i),  32'(bus.dim_err), 32'(vecs[i].exp_err));
      check($sformatf("dim%0d_busy", i), 32'(bus.busy),    32'(vecs[i].exp_busy));
      check($sformatf("dim%0d_tx", i),   32'(bus.uart_tx), 32'(!vecs[i].exp_busy));
      @(negedge clk);
      check($sformatf("dim%0d_err_pulse", i), 32'(bus.dim_err), 32'd0);
      check($sformatf("dim%0d_busy_hold", i), 32'(bus.busy),    32'(vecs[i].exp_busy));
      if (vecs[i].exp_busy) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check($sformatf("dim%0d_abort_busy", i), 32'(bus.busy),    32'd0);
        check($sformatf("dim%0d_abort_tx", i),   32'(bus.uart_tx), 32'd1);
      end
    end
    rx_q.delete();

    // 1x1 frame
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) model_w[r][c] = '0;
    model_w[0][0] = 32'h12345678;
    drive_inputs(1, 1);
    expect_frame(1, 1);
    launch("f11");
    wait_frame("f11", 1, 1, 1'b0, 1'b0);
    compare_rx("f11");

    // 2x2 frame; inputs scrambled and a second start issued mid-frame
    model_w[0][0] = 32'd1; model_w[0][1] = 32'd2;
    model_w[1][0] = 32'd3; model_w[1][1] = 32'd4;
    drive_inputs(2, 2);
    expect_frame(2, 2);
    launch("f22");
    wait_frame("f22", 2, 2, 1'b1, 1'b0);
    compare_rx("f22");

    // start during the DONE cycle chains a new frame immediately
    fill_random();
    drive_inputs(1, 2);
    expect_frame(1, 2);
    launch("chainA");
    fill_random();
    drive_inputs(2, 1);
    expect_frame(2, 1);
    wait_frame("chainA", 1, 2, 1'b0, 1'b1);
    @(negedge clk);
    bus.start = 1'b0;
    check("chainB_busy",  32'(bus.busy),    32'd1);
    check("chainB_start", 32'(bus.uart_tx), 32'd0);
    check("chainB_done",  32'(bus.done),    32'd0);
    wait_frame("chainB", 2, 1, 1'b0, 1'b0);
    compare_rx("chain");

    // reset during the fifth byte
    fill_random();
    drive_inputs(2, 2);
    expect_frame(2, 2);
    launch("abort");
    repeat (699) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_tx",      32'(bus.uart_tx), 32'd1);
    check("abort_busy",    32'(bus.busy),    32'd0);
    check("abort_done",    32'(bus.done),    32'd0);
    check("abort_rx_keep", 32'(rx_q.size()), 32'd4);
    saw_done = 1'b0;
    saw_low  = 1'b0;
    repeat (300) begin
      @(negedge clk);
      if (bus.done !== 1'b0) saw_done = 1'b1;
      if (bus.uart_tx !== 1'b1) saw_low = 1'b1;
    end
    check("abort_no_done", 32'(saw_done), 32'd0);
    check("abort_line_idle", 32'(saw_low), 32'd0);
    rx_q.delete();
    exp_q.delete();
    fill_random();
    drive_inputs(2, 2);
    expect_frame(2, 2);
    launch("after_abort");
    wait_frame("after_abort", 2, 2, 1'b0, 1'b0);
    compare_rx("after_abort");

    // random frames
    for (int k = 0; k < 4; k++) begin
      m = $urandom_range(1, 4);
      p = $urandom_range(1, 3);
      fill_random();
      drive_inputs(m, p);
      expect_frame(m, p);
      launch($sformatf("rnd%0d", k));
      wait_frame($sformatf("rnd%0d", k), m, p, 1'($urandom_range(0, 1)), 1'b0);
      compare_rx($sformatf("rnd%0d", k));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
